if_stage: RTL and testbench

- Instruction-fetch stage of the OpenMIPS five-stage pipeline inside openmips_min_sopc.
- Generates the PC and the instruction-ROM chip enable, and drives the ROM address.
- Registers the PC and the fetched instruction into the IF/ID pipeline register that feeds decode.
- Honours pipeline stall, branch redirect and exception flush from ctrl/id/ex.

---
 rtl/if_stage.sv | 92 +++++++++
 tb/tb_if_stage.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC generation, ROM chip enable and the IF/ID pipeline register.
// Exception flush outranks stall, and stall outranks a branch redirect.
module if_stage #(
    parameter int                 ADDR_W   = 32,
    parameter int                 INST_W   = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        stall_i,
    input  logic              flush_i,
    input  logic [ADDR_W-1:0] new_pc_i,
    input  logic              branch_flag_i,
    input  logic [ADDR_W-1:0] branch_target_i,
    input  logic [INST_W-1:0] rom_inst_i,
    output logic [ADDR_W-1:0] rom_addr_o,
    output logic              rom_ce_o,
    output logic [ADDR_W-1:0] id_pc_o,
    output logic [INST_W-1:0] id_inst_o,
    output logic              id_valid_o,
    output logic              id_adel_o
);

    logic              rom_ce_q;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] id_pc_q, id_pc_d;
    logic [INST_W-1:0] id_inst_q, id_inst_d;
    logic              id_valid_q, id_valid_d;
    logic              id_adel_q, id_adel_d;
    logic              pc_misaligned;

    assign pc_misaligned = (pc_q[1:0] != 2'b00);

    // PC holds at RESET_PC until the chip enable has been registered high.
    always_comb begin
        pc_d = pc_q;
        if (rom_ce_q) begin
            if (flush_i)
                pc_d = new_pc_i;
            else if (stall_i[0])
                pc_d = pc_q;
            else if (branch_flag_i)
                pc_d = branch_target_i;
            else
                pc_d = pc_q + ADDR_W'(4);
        end
    end

    always_comb begin
        id_pc_d    = id_pc_q;
        id_inst_d  = id_inst_q;
        id_valid_d = id_valid_q;
        id_adel_d  = id_adel_q;
        if (flush_i || (stall_i[1] && !stall_i[2])) begin
            id_pc_d    = '0;
            id_inst_d  = '0;
            id_valid_d = 1'b0;
            id_adel_d  = 1'b0;
        end else if (!stall_i[1]) begin
            id_pc_d    = pc_q;
            id_inst_d  = rom_ce_q ? rom_inst_i : '0;
            id_valid_d = rom_ce_q;
            id_adel_d  = rom_ce_q & pc_misaligned;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rom_ce_q   <= 1'b0;
            pc_q       <= RESET_PC;
            id_pc_q    <= '0;
            id_inst_q  <= '0;
            id_valid_q <= 1'b0;
            id_adel_q  <= 1'b0;
        end else begin
            rom_ce_q   <= 1'b1;
            pc_q       <= pc_d;
            id_pc_q    <= id_pc_d;
            id_inst_q  <= id_inst_d;
            id_valid_q <= id_valid_d;
            id_adel_q  <= id_adel_d;
        end
    end

    assign rom_addr_o = pc_q;
    assign rom_ce_o   = rom_ce_q;
    assign id_pc_o    = id_pc_q;
    assign id_inst_o  = id_inst_q;
    assign id_valid_o = id_valid_q;
    assign id_adel_o  = id_adel_q;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed fetch/stall/branch/flush scenarios followed by randomized
// control traffic, all compared against a cycle-level reference model of the fetch stage.
module tb_if_stage;

    logic        clk = 1'b1;
    logic        rst;
    logic [2:0]  stall_i;
    logic        flush_i;
    logic [31:0] new_pc_i;
    logic        branch_flag_i;
    logic [31:0] branch_target_i;
    logic [31:0] rom_inst_i;
    logic [31:0] rom_addr_o;
    logic        rom_ce_o;
    logic [31:0] id_pc_o;
    logic [31:0] id_inst_o;
    logic        id_valid_o;
    logic        id_adel_o;

    logic [31:0] rom [0:63];

    int n_chk  = 0;
    int n_fail = 0;

    // reference model state
    logic        m_ce;
    logic [31:0] m_pc, m_id_pc, m_id_inst;
    logic        m_vld, m_adel;

    if_stage #(.ADDR_W(32), .INST_W(32), .RESET_PC(32'h0)) dut (
        .clk             (clk),
        .rst             (rst),
        .stall_i         (stall_i),
        .flush_i         (flush_i),
        .new_pc_i        (new_pc_i),
        .branch_flag_i   (branch_flag_i),
        .branch_target_i (branch_target_i),
        .rom_inst_i      (rom_inst_i),
        .rom_addr_o      (rom_addr_o),
        .rom_ce_o        (rom_ce_o),
        .id_pc_o         (id_pc_o),
        .id_inst_o       (id_inst_o),
        .id_valid_o      (id_valid_o),
        .id_adel_o       (id_adel_o)
    );

    always #5 clk = ~clk;

    assign rom_inst_i = rom[rom_addr_o[7:2]];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ce = 1'b0; m_pc = 32'h0;
        m_id_pc = 32'h0; m_id_inst = 32'h0; m_vld = 1'b0; m_adel = 1'b0;
    endtask

    // One clock edge of the fetch stage, computed from the previous model state.
    task automatic model_edge();
        logic [31:0] pc_old;
        logic        ce_old;
        pc_old = m_pc;
        ce_old = m_ce;
        if (flush_i || (stall_i[1] && !stall_i[2])) begin
            m_id_pc = 32'h0; m_id_inst = 32'h0; m_vld = 1'b0; m_adel = 1'b0;
        end else if (!stall_i[1]) begin
            m_id_pc   = pc_old;
            m_id_inst = ce_old ? rom[pc_old[7:2]] : 32'h0;
            m_vld     = ce_old;
            m_adel    = ce_old && (pc_old % 4 != 0);
        end
        if (!ce_old)            m_ce = 1'b1;
        else if (flush_i)       m_pc = new_pc_i;
        else if (stall_i[0])    m_pc = pc_old;
        else if (branch_flag_i) m_pc = branch_target_i;
        else                    m_pc = pc_old + 32'd4;
    endtask

    task automatic compare_all();
        check("rom_ce", 64'(rom_ce_o), 64'(m_ce));
        check("pc", 64'(rom_addr_o), 64'(m_pc));
        check("id_pc", 64'(id_pc_o), 64'(m_id_pc));
        check("id_inst", 64'(id_inst_o), 64'(m_id_inst));
        check("id_valid", 64'(id_valid_o), 64'(m_vld));
        check("id_adel", 64'(id_adel_o), 64'(m_adel));
    endtask

    task automatic idle_inputs();
        stall_i = 3'b000; flush_i = 1'b0; branch_flag_i = 1'b0;
        new_pc_i = 32'h0; branch_target_i = 32'h0;
    endtask

    task automatic step();
        @(posedge clk);
        if (rst) model_reset();
        else model_edge();
        #1;
        compare_all();
    endtask

    initial begin
        rom[0] = 32'h3401_1100;
        rom[1] = 32'h3402_0020;
        for (int i = 2; i < 64; i++) rom[i] = $urandom;

        rst = 1'b1;
        idle_inputs();
        model_reset();
        #45;
        compare_all();
        check("reset_ce", 64'(rom_ce_o), 64'h0);

        #150; // 195 ns
        rst = 1'b0;
        step();
        check("ce_rise", 64'(rom_ce_o), 64'h1);
        check("first_pc", 64'(rom_addr_o), 64'h0);
        step();
        check("first_inst", 64'(id_inst_o), 64'h3401_1100);
        check("first_id_pc", 64'(id_pc_o), 64'h0);
        check("first_valid", 64'(id_valid_o), 64'h1);

        begin
            int budget = 10;
            while (rom_addr_o != 32'h10 && budget > 0) begin
                step();
                budget--;
            end
            check("reach_pc10", 64'(rom_addr_o), 64'h10);
        end

        // full stall for three cycles
        stall_i = 3'b111;
        repeat (3) step();
        check("stall_hold_pc", 64'(rom_addr_o), 64'h10);
        check("stall_hold_id", 64'(id_pc_o), 64'hC);
        stall_i = 3'b000;
        step();
        check("resume_pc", 64'(rom_addr_o), 64'h14);
        check("resume_id", 64'(id_pc_o), 64'h10);

        // one-cycle IF stall -> single bubble
        stall_i = 3'b011;
        step();
        check("bubble_valid", 64'(id_valid_o), 64'h0);
        check("bubble_inst", 64'(id_inst_o), 64'h0);
        stall_i = 3'b000;
        step();
        check("after_bubble_valid", 64'(id_valid_o), 64'h1);

        // position pc at 0x0C, then branch to 0x40
        flush_i = 1'b1; new_pc_i = 32'h0C;
        step();
        idle_inputs();
        branch_flag_i = 1'b1; branch_target_i = 32'h40;
        step();
        check("br_pc", 64'(rom_addr_o), 64'h40);
        check("delay_slot_pc", 64'(id_pc_o), 64'hC);
        check("delay_slot_inst", 64'(id_inst_o), 64'(rom[3]));
        idle_inputs();
        step();

        // flush beats a full stall
        stall_i = 3'b111; flush_i = 1'b1; new_pc_i = 32'h20;
        step();
        check("flush_pc", 64'(rom_addr_o), 64'h20);
        check("flush_valid", 64'(id_valid_o), 64'h0);
        idle_inputs();
        step();

        // misaligned branch target
        branch_flag_i = 1'b1; branch_target_i = 32'h42;
        step();
        idle_inputs();
        step();
        check("adel_flag", 64'(id_adel_o), 64'h1);
        check("adel_pc", 64'(id_pc_o), 64'h42);

        // wrap-around at the top of the address space
        flush_i = 1'b1; new_pc_i = 32'hFFFF_FFFC;
        step();
        idle_inputs();
        step();
        check("wrap_pc", 64'(rom_addr_o), 64'h0);

        // randomized control traffic with legal stall vectors
        for (int i = 0; i < 400; i++) begin
            int r;
            r = $urandom_range(0, 9);
            case (r)
                0, 1:    stall_i = 3'b001;
                2:       stall_i = 3'b011;
                3:       stall_i = 3'b111;
                default: stall_i = 3'b000;
            endcase
            flush_i         = ($urandom_range(0, 19) == 0);
            new_pc_i        = 32'($urandom_range(0, 255));
            branch_flag_i   = ($urandom_range(0, 6) == 0);
            branch_target_i = 32'($urandom_range(0, 255));
            if ($urandom_range(0, 15) == 0) branch_target_i = 32'hFFFF_FFF8;
            step();
        end

        // asynchronous reset pulse between edges
        idle_inputs();
        step();
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        compare_all();
        check("async_clear_valid", 64'(id_valid_o), 64'h0);
        #1;
        rst = 1'b0;
        step();
        check("restart_ce", 64'(rom_ce_o), 64'h1);
        repeat (5) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
